// File: rtl/lsu_sequencer.sv
// MEM-stage load/store sequencer: one req/ack bus transaction at a time, with lane steering and load formatting.
// Optional MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of silently aligning them down.
module lsu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            rd_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    logic            req_c;
    logic            rd_c;
    logic            bad_f3_c;
    logic            misalign_c;
    logic            reject_c;
    logic            to_hit_c;
    logic [3:0]      be_c;
    logic [31:0]     wdata_c;

    // Sign/zero-extend the addressed byte or half of a returned word.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3[1:0])
            2'b00:   fmt_load = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   fmt_load = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: fmt_load = d;
        endcase
    endfunction

    // Request decode and lane steering; a simultaneous read+write is a read.
    always_comb begin
        req_c      = ex_mem_read | ex_mem_write;
        rd_c       = ex_mem_read;
        bad_f3_c   = 1'b0;
        misalign_c = 1'b0;
        be_c       = 4'hF;
        wdata_c    = ex_wdata;

        if (rd_c)
            bad_f3_c = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
        else
            bad_f3_c = (ex_funct3 == 3'b011) || ex_funct3[2];

`ifdef MISALIGN_TRAP_EN
        misalign_c = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                     ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif

        case (ex_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ex_addr[1:0];
                wdata_c = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ex_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'hF;
                wdata_c = ex_wdata;
            end
        endcase

        if (rd_c) begin
            be_c    = 4'hF;
            wdata_c = 32'h0;
        end

        reject_c = bad_f3_c | misalign_c;
        to_hit_c = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
    end

    // The completing instruction advances in RESP, so only the accept cycle and BUSY hold the pipe.
    assign stall = ~rst & (((state == IDLE) & req_c) | (state == BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            to_cnt       <= '0;
            rd_q         <= 1'b0;
            f3_q         <= 3'b0;
            off_q        <= 2'b0;
            load_data    <= 32'h0;
            load_valid   <= 1'b0;
            access_fault <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_wdata    <= 32'h0;
            bus_be       <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    load_valid   <= 1'b0;
                    access_fault <= 1'b0;
                    if (req_c) begin
                        rd_q   <= rd_c;
                        f3_q   <= ex_funct3;
                        off_q  <= ex_addr[1:0];
                        to_cnt <= '0;
                        if (reject_c) begin
                            state        <= RESP;
                            access_fault <= 1'b1;
                        end else begin
                            state     <= BUSY;
                            bus_req   <= 1'b1;
                            bus_we    <= ~rd_c;
                            bus_addr  <= {ex_addr[31:2], 2'b00};
                            bus_wdata <= wdata_c;
                            bus_be    <= be_c;
                        end
                    end
                end
                BUSY: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (bus_err) begin
                        state        <= RESP;
                        bus_req      <= 1'b0;
                        access_fault <= 1'b1;
                    end else if (bus_ack) begin
                        state   <= RESP;
                        bus_req <= 1'b0;
                        if (rd_q) begin
                            load_valid <= 1'b1;
                            load_data  <= fmt_load(f3_q, off_q, bus_rdata);
                        end
                    end else if (to_hit_c) begin
                        state        <= RESP;
                        bus_req      <= 1'b0;
                        access_fault <= 1'b1;
                    end
                end
                RESP: begin
                    load_valid   <= 1'b0;
                    access_fault <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer with a 4-cycle bus timeout.
module tb_lsu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    lsu_sequencer #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .access_fault(access_fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_addr      = a;
        ex_wdata     = d;
    endtask

    task automatic drop();
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;

        // reset state
        tick(); tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_load_valid", load_valid, 0);
        chk("rst_fault", access_fault, 0);
        ex_mem_read = 1'b1; #1;
        chk("rst_stall_forced", stall, 0);
        ex_mem_read = 1'b0;
        rst = 1'b0;
        tick();

        // SW 0x100, ack in second BUSY cycle
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF); #1;
        chk("sw_stall_c1", stall, 1);
        tick(); drop(); #1;
        chk("sw_req", bus_req, 1);
        chk("sw_we", bus_we, 1);
        chk("sw_addr", bus_addr, 32'h100);
        chk("sw_be", bus_be, 4'hF);
        chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
        chk("sw_stall_c2", stall, 1);
        tick();
        chk("sw_stall_c3", stall, 1);
        chk("sw_req_held", bus_req, 1);
        bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("sw_resp_stall", stall, 0);
        chk("sw_resp_req", bus_req, 0);
        chk("sw_no_load_valid", load_valid, 0);
        chk("sw_no_fault", access_fault, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h0); // ignored in RESP
        tick();
        chk("resp_ignore_req", bus_req, 0);
        drop(); #1;
        chk("idle_stall_low", stall, 0);

        // SB 0x103 with immediate ack
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5);
        tick(); drop();
        chk("sb_be", bus_be, 4'b1000);
        chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
        chk("sb_addr", bus_addr, 32'h100);
        bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("sb_no_fault", access_fault, 0);
        chk("sb_no_load_valid", load_valid, 0);
        tick();

        // LB then LBU at 0x202
        issue(1'b1, 1'b0, 3'b000, 32'h202, 32'h0);
        tick(); drop();
        chk("lb_we", bus_we, 0);
        chk("lb_be", bus_be, 4'hF);
        chk("lb_addr", bus_addr, 32'h200);
        bus_rdata = 32'h12807F34; bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("lb_valid", load_valid, 1);
        chk("lb_data", load_data, 32'hFFFFFF80);
        tick();
        chk("lb_valid_pulse", load_valid, 0);
        chk("lb_data_hold", load_data, 32'hFFFFFF80);
        issue(1'b1, 1'b0, 3'b100, 32'h202, 32'h0);
        tick(); drop();
        bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("lbu_valid", load_valid, 1);
        chk("lbu_data", load_data, 32'h00000080);
        tick();

        // LW with no response: times out after 4 BUSY cycles
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        tick(); drop();
        chk("to_req_c1", bus_req, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("to_req_held", bus_req, 1);
            chk("to_stall_held", stall, 1);
        end
        tick();
        chk("to_fault", access_fault, 1);
        chk("to_no_valid", load_valid, 0);
        chk("to_req_drop", bus_req, 0);
        chk("to_data_hold", load_data, 32'h00000080);
        tick();
        chk("to_fault_pulse", access_fault, 0);

        // ack and err together: err wins
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        tick(); drop();
        bus_rdata = 32'hFFFFFFFF; bus_ack = 1'b1; bus_err = 1'b1;
        tick(); bus_ack = 1'b0; bus_err = 1'b0;
        chk("err_fault", access_fault, 1);
        chk("err_no_valid", load_valid, 0);
        chk("err_data_hold", load_data, 32'h00000080);
        tick();

        // LH at misaligned 0x301
        issue(1'b1, 1'b0, 3'b001, 32'h301, 32'h0); #1;
        chk("lh_accept_stall", stall, 1);
        tick(); drop(); #1;
`ifdef MISALIGN_TRAP_EN
        chk("lh_trap_no_req", bus_req, 0);
        chk("lh_trap_fault", access_fault, 1);
        chk("lh_trap_stall", stall, 0);
        tick();
`else
        chk("lh_req", bus_req, 1);
        chk("lh_addr", bus_addr, 32'h300);
        bus_rdata = 32'hCAFE8001; bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("lh_valid", load_valid, 1);
        chk("lh_data", load_data, 32'hFFFF8001);
        chk("lh_no_fault", access_fault, 0);
        tick();
`endif

        // reserved store funct3: fault without a bus cycle
        issue(1'b0, 1'b1, 3'b100, 32'h600, 32'h1234);
        tick(); drop();
        chk("rsv_no_req", bus_req, 0);
        chk("rsv_fault", access_fault, 1);
        tick();

        // reset in BUSY, then a normal LW
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        tick(); drop();
        chk("mid_rst_req_before", bus_req, 1);
        rst = 1'b1; #1;
        chk("mid_rst_req", bus_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_load_data", load_data, 0);
        tick(); rst = 1'b0;
        tick();
        chk("post_rst_no_valid", load_valid, 0);
        chk("post_rst_no_fault", access_fault, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h404, 32'h0);
        tick(); drop();
        chk("post_rst_addr", bus_addr, 32'h404);
        chk("post_rst_req", bus_req, 1);
        bus_rdata = 32'h11223344; bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("post_rst_valid", load_valid, 1);
        chk("post_rst_data", load_data, 32'h11223344);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
